// File: rtl/pc_stack.sv
// Program counter with a hardware return-address stack.
// Control strobes are resolved in a fixed priority order:
// stall > ret > call > absolute branch > relative branch > increment.
// Only the winning action updates PC, the stack and the sticky error flag.
module pc_stack #(
  parameter int               Psize    = 8,
  parameter int               Depth    = 4,
  parameter logic [Psize-1:0] ResetVec = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       PCstall,
  input  logic                       PCincr,
  input  logic                       PCabsbranch,
  input  logic                       PCrelbranch,
  input  logic                       PCcall,
  input  logic                       PCret,
  input  logic [Psize-1:0]           Branchaddr,
  output logic [Psize-1:0]           PCout,
  output logic [$clog2(Depth+1)-1:0] StackCount,
  output logic                       StackFull,
  output logic                       StackEmpty,
  output logic                       StackErr
);

  localparam int Cw = $clog2(Depth + 1);
  localparam int Aw = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [Cw-1:0] FullCnt = Cw'(Depth);

  logic [Psize-1:0] pc_q, pc_d, pc_inc;
  logic [Cw-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             push;
  logic [Aw-1:0]    push_idx, top_idx;
  logic [Psize-1:0] stack_q [Depth];

  assign pc_inc   = pc_q + Psize'(1);
  // Free slot is at index cnt; top of stack at cnt-1 (only read when non-empty).
  assign push_idx = Aw'(cnt_q);
  assign top_idx  = Aw'(cnt_q - Cw'(1));

  // Resolve strobe priority into next PC, stack depth, error flag and push enable.
  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    err_d = err_q;
    push  = 1'b0;
    if (PCstall) begin
      pc_d = pc_q;
    end else if (PCret) begin
      if (cnt_q == '0) begin
        // Underflow behaves as a no-op instruction.
        pc_d  = pc_inc;
        err_d = 1'b1;
      end else begin
        pc_d  = stack_q[top_idx];
        cnt_d = cnt_q - Cw'(1);
      end
    end else if (PCcall) begin
      // The jump is taken even when the return address cannot be saved.
      pc_d = Branchaddr;
      if (cnt_q == FullCnt) begin
        err_d = 1'b1;
      end else begin
        push  = 1'b1;
        cnt_d = cnt_q + Cw'(1);
      end
    end else if (PCabsbranch) begin
      pc_d = Branchaddr;
    end else if (PCrelbranch) begin
      // Modulo-2^Psize addition is identical to adding the sign-extended offset.
      pc_d = pc_q + Branchaddr;
    end else if (PCincr) begin
      pc_d = pc_inc;
    end
  end

  // PC, stack depth and sticky error register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= ResetVec;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Return-address storage; contents are meaningless above the current depth.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign PCout      = pc_q;
  assign StackCount = cnt_q;
  assign StackFull  = (cnt_q == FullCnt);
  assign StackEmpty = (cnt_q == '0);
  assign StackErr   = err_q;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: directed scenarios followed by random
// strobe patterns, all compared against a queue-based reference model.
module tb_pc_stack;

  localparam int         PSIZE = 8;
  localparam int         DEPTH = 4;
  localparam logic [7:0] RVEC  = 8'h20;

  // Strobe encoding: {stall, ret, call, abs, rel, incr}
  localparam logic [5:0] STALL = 6'b100000;
  localparam logic [5:0] RET   = 6'b010000;
  localparam logic [5:0] CALL  = 6'b001000;
  localparam logic [5:0] ABS   = 6'b000100;
  localparam logic [5:0] REL   = 6'b000010;
  localparam logic [5:0] INC   = 6'b000001;

  logic       clk = 1'b0;
  logic       reset;
  logic       PCstall, PCincr, PCabsbranch, PCrelbranch, PCcall, PCret;
  logic [7:0] Branchaddr;
  logic [7:0] PCout;
  logic [2:0] StackCount;
  logic       StackFull, StackEmpty, StackErr;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_err;

  pc_stack #(.Psize(PSIZE), .Depth(DEPTH), .ResetVec(RVEC)) dut (
    .clk(clk), .reset(reset),
    .PCstall(PCstall), .PCincr(PCincr), .PCabsbranch(PCabsbranch),
    .PCrelbranch(PCrelbranch), .PCcall(PCcall), .PCret(PCret),
    .Branchaddr(Branchaddr), .PCout(PCout), .StackCount(StackCount),
    .StackFull(StackFull), .StackEmpty(StackEmpty), .StackErr(StackErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = RVEC;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic [5:0] ctl, input logic [7:0] addr);
    if (ctl[5]) begin
      // stall: nothing changes
    end else if (ctl[4]) begin
      if (m_stk.size() == 0) begin
        m_pc  = m_pc + 8'd1;
        m_err = 1'b1;
      end else begin
        m_pc = m_stk.pop_back();
      end
    end else if (ctl[3]) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 8'd1);
      else m_err = 1'b1;
      m_pc = addr;
    end else if (ctl[2]) begin
      m_pc = addr;
    end else if (ctl[1]) begin
      m_pc = 8'(int'(m_pc) + int'($signed(addr)));
    end else if (ctl[0]) begin
      m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".pc"},    32'(PCout),      32'(m_pc));
    chk({tag, ".cnt"},   32'(StackCount), 32'(m_stk.size()));
    chk({tag, ".full"},  32'(StackFull),  32'(m_stk.size() == DEPTH));
    chk({tag, ".empty"}, 32'(StackEmpty), 32'(m_stk.size() == 0));
    chk({tag, ".err"},   32'(StackErr),   32'(m_err));
  endtask

  task automatic step(input string tag, input logic [5:0] ctl, input logic [7:0] addr);
    @(negedge clk);
    {PCstall, PCret, PCcall, PCabsbranch, PCrelbranch, PCincr} = ctl;
    Branchaddr = addr;
    @(posedge clk);
    model_step(ctl, addr);
    #1;
    compare_all(tag);
  endtask

  // Reset is raised between edges so its effect must show without a clock.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare_all(tag);
    @(negedge clk);
    {PCstall, PCret, PCcall, PCabsbranch, PCrelbranch, PCincr} = 6'b0;
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] ctl;
    reset = 1'b1;
    {PCstall, PCret, PCcall, PCabsbranch, PCrelbranch, PCincr} = 6'b0;
    Branchaddr = 8'h00;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step("pre", ABS, 8'h77);

    // Asynchronous reset and counting from the reset vector
    do_reset("rst");
    chk("rst.pc_lit", 32'(PCout), 32'h20);
    step("inc1", INC, 8'h00); chk("inc1.lit", 32'(PCout), 32'h21);
    step("inc2", INC, 8'h00); chk("inc2.lit", 32'(PCout), 32'h22);
    step("inc3", INC, 8'h00); chk("inc3.lit", 32'(PCout), 32'h23);

    // Wrap and relative branches
    step("setff", ABS, 8'hFF);
    step("wrap", INC, 8'h00); chk("wrap.lit", 32'(PCout), 32'h00);
    step("set10", ABS, 8'h10);
    step("relneg", REL, 8'hFE); chk("relneg.lit", 32'(PCout), 32'h0E);
    step("setf0", ABS, 8'hF0);
    step("relwrap", REL, 8'h20); chk("relwrap.lit", 32'(PCout), 32'h10);

    // Nested call/return
    step("set05", ABS, 8'h05);
    step("call1", CALL, 8'h40); chk("call1.lit", 32'(PCout), 32'h40);
    step("inc41", INC, 8'h00);
    step("call2", CALL, 8'h80); chk("call2.cnt_lit", 32'(StackCount), 32'd2);
    step("ret1", RET, 8'h00); chk("ret1.lit", 32'(PCout), 32'h42);
    step("ret2", RET, 8'h00); chk("ret2.lit", 32'(PCout), 32'h06);

    // Overflow then underflow: pushes 07,11,21,31
    for (int i = 0; i < DEPTH; i++) step("fill", CALL, 8'(8'h10 * (i + 1)));
    chk("fill.full_lit", 32'(StackFull), 32'd1);
    step("ovf", CALL, 8'h90);
    chk("ovf.pc_lit", 32'(PCout), 32'h90);
    chk("ovf.err_lit", 32'(StackErr), 32'd1);
    step("pop4", RET, 8'h00); chk("pop4.lit", 32'(PCout), 32'h31);
    step("pop3", RET, 8'h00); chk("pop3.lit", 32'(PCout), 32'h21);
    step("pop2", RET, 8'h00); chk("pop2.lit", 32'(PCout), 32'h11);
    step("pop1", RET, 8'h00); chk("pop1.lit", 32'(PCout), 32'h07);
    step("unf", RET, 8'h00); chk("unf.lit", 32'(PCout), 32'h08);

    // Priority and stall
    step("stall", STALL | CALL | INC, 8'h77); chk("stall.lit", 32'(PCout), 32'h08);
    step("set32", ABS, 8'h32);
    step("push33", CALL, 8'h60);
    step("retwin", RET | CALL | INC, 8'h99); chk("retwin.lit", 32'(PCout), 32'h33);
    step("abswin", ABS | REL | INC, 8'h50); chk("abswin.lit", 32'(PCout), 32'h50);

    // Reset in the middle of a call sequence
    step("mcall1", CALL, 8'h11);
    step("mcall2", CALL, 8'h22);
    do_reset("mrst");
    step("mret", RET, 8'h00); chk("mret.err_lit", 32'(StackErr), 32'd1);

    // Random strobe mixes with occasional resets
    do_reset("rrst");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rnd_rst");
      end else begin
        ctl = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 7) != 0) ctl[5] = 1'b0;
        step("rnd", ctl, 8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter for the microprocessor datapath.
- Adds a hardware return-address stack (call/return), signed relative branches, a pipeline stall/hold input, a configurable reset vector and stack error reporting.
- Sits between the control unit, which supplies one-hot-ish control strobes, and the instruction memory address port.

Parameters:
Psize, 8, PC / address width in bits (≥4)
Depth, 4, return-address stack entries (≥1)
ResetVec, 0, PC value loaded on reset (Psize bits)

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-high reset
PCstall  input  1  hold PC and stack this cycle
PCincr  input  1  PC <= PC + 1
PCabsbranch  input  1  PC <= Branchaddr
PCrelbranch  input  1  PC <= PC + signed(Branchaddr)
PCcall  input  1  push PC+1, PC <= Branchaddr
PCret  input  1  pop top of stack into PC
Branchaddr  input  Psize  absolute target, or two's-complement offset for relative branch
PCout  output  Psize  current PC (registered)
StackCount  output  $clog2(Depth+1)  number of valid stack entries
StackFull  output  1  StackCount == Depth
StackEmpty  output  1  StackCount == 0
StackErr  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (async, active-high): PC = ResetVec, StackCount = 0, StackErr = 0. Stack contents are don't-care. Outputs reflect reset immediately, without waiting for a clock edge. Reset mid-call/ret aborts the operation; no partial push.
- All state updates on rising clk when reset is low. PCout is the PC register with 0-cycle output latency; new PC is visible the cycle after the strobe.
- Priority when several strobes are high in one cycle (highest first):
  - PCstall: everything holds, StackErr included.
  - PCret
  - PCcall
  - PCabsbranch
  - PCrelbranch
  - PCincr
  - none: hold.
- Only the winning action takes effect.
- PCincr: PC <= PC + 1, modulo 2^Psize. From all-ones the PC wraps to 0.
- PCrelbranch: Branchaddr is sign-extended. PC <= PC + offset, modulo 2^Psize. Example at Psize=8: PC=0x10, offset 0xFE gives 0x0E.
- PCabsbranch: PC <= Branchaddr.
- PCcall, not full:
  - stack[StackCount] <= PC + 1 (wrapping).
  - StackCount += 1.
  - PC <= Branchaddr.
- PCcall when full:
  - Jump still taken (PC <= Branchaddr).
  - Push discarded; existing entries unchanged; StackCount unchanged.
  - StackErr <= 1.
- PCret, not empty:
  - PC <= stack[StackCount-1].
  - StackCount -= 1.
- PCret when empty:
  - PC <= PC + 1 (treated as a no-op instruction).
  - StackCount stays 0.
  - StackErr <= 1.
- StackErr is sticky and is cleared only by reset.
- The stack is LIFO, with storage of Depth × Psize flops indexed by StackCount. No combinational path from inputs to PCout.
- StackFull and StackEmpty are decoded combinationally from the registered StackCount.

Test Plan:
- Reset with ResetVec=0x20: assert reset asynchronously between edges -> PCout=0x20 immediately, StackEmpty=1, StackErr=0. Deassert reset, hold PCincr for 3 cycles -> PCout 0x21, 0x22, 0x23.
- Wrap and relative branch (Psize=8): PC=0xFF with PCincr -> 0x00. PC=0x10 with PCrelbranch, Branchaddr=0xFE -> 0x0E. PC=0xF0 with PCrelbranch, Branchaddr=0x20 -> 0x10.
- Nested call/return (Depth=4):
  - PC=0x05, call 0x40 -> PC=0x40, StackCount=1.
  - PCincr, then call 0x80 -> PC=0x80, StackCount=2.
  - ret -> PC=0x42.
  - ret -> PC=0x06, StackEmpty=1, StackErr=0.
- Overflow/underflow:
  - 4 calls fill the stack (StackFull=1).
  - 5th call to 0x90 -> PC=0x90, StackCount=4, StackErr=1.
  - 4 rets return the correct 4 addresses in LIFO order.
  - 5th ret from PC=X -> PC=X+1, StackErr remains 1.
- Priority and stall:
  - PCstall with PCcall and PCincr high -> PC, StackCount and StackErr unchanged.
  - PCret+PCcall+PCincr with one entry 0x33 -> PC=0x33, StackCount=0.
  - PCabsbranch(0x50)+PCrelbranch+PCincr -> PC=0x50.
- Reset mid-sequence: after 2 calls, assert reset -> PC=ResetVec, StackCount=0, StackErr=0. The next ret underflows and sets StackErr.
